light_reg_ctrl: RTL and testbench

//  Memory-mapped CPU slave that drives the two-digit seven-segment display driver.
//  It holds the display value and the control registers, and converts the value to
//  hex or decimal. Output O_show_num feeds the display driver's 8-bit show-number

---
 rtl/light_pkg.sv | 37 +++
 rtl/light_reg_ctrl_if.sv | 28 ++
 rtl/light_bin2bcd.sv | 60 ++++++
 rtl/light_reg_ctrl.sv | 144 ++++++++++++++
 tb/tb_light_reg_ctrl.sv | 213 +++++++++++++++++++++
 5 files changed

// File: rtl/light_pkg.sv
`default_nettype none
// ============================================================================
// Module  : light_pkg
// Brief   : Shared constants and types for the seven-segment light controller.
// Revision: 1.0
// ============================================================================
package light_pkg;

  localparam logic [1:0] REG_DATA = 2'd0;
  localparam logic [1:0] REG_CTRL = 2'd1;
  localparam logic [1:0] REG_DIV  = 2'd2;
  localparam logic [1:0] REG_STAT = 2'd3;

  localparam int CTRL_EN    = 0;
  localparam int CTRL_DEC   = 1;
  localparam int CTRL_BLINK = 2;

  localparam logic [7:0] DEC_SAT = 8'd99;

  typedef enum logic [1:0] {
    BUS_IDLE = 2'd0,
    BUS_ACK  = 2'd1,
    BUS_GAP  = 2'd2
  } bus_state_t;

  typedef enum logic {
    CNV_IDLE = 1'b0,
    CNV_SUB  = 1'b1
  } cnv_state_t;

  // Values above the two-digit decimal range are pinned to 99.
  function automatic logic [6:0] dec_clamp(input logic [7:0] v);
    return 7'((v > DEC_SAT) ? DEC_SAT : v);
  endfunction

endpackage
`default_nettype wire

// File: rtl/light_reg_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module  : light_reg_ctrl_if
// Brief   : CPU peripheral bus request/acknowledge interface.
// Revision: 1.0
// ============================================================================
interface light_reg_ctrl_if;
  import light_pkg::*;

  logic        I_req;
  logic        I_we;
  logic [3:0]  I_addr;
  logic [31:0] I_wdata;
  logic        O_ack;
  logic [31:0] O_rdata;

  modport master (
    output I_req, I_we, I_addr, I_wdata,
    input  O_ack, O_rdata
  );

  modport slave (
    input  I_req, I_we, I_addr, I_wdata,
    output O_ack, O_rdata
  );

endinterface
`default_nettype wire

// File: rtl/light_bin2bcd.sv
`default_nettype none
// ============================================================================
// Module  : light_bin2bcd
// Brief   : Binary (0..99) to two-digit BCD by repeated subtraction of ten.
// Revision: 1.0
// ============================================================================
module light_bin2bcd
  import light_pkg::*;
(
  input  logic       I_clk,
  input  logic       I_rst_n,
  input  logic       start,
  input  logic [6:0] value,
  output logic       busy,
  output logic       done,
  output logic [7:0] bcd
);

  cnv_state_t state, state_nxt;
  logic [6:0] rem, rem_nxt;
  logic [3:0] tens, tens_nxt;

  always_ff @(posedge I_clk or negedge I_rst_n) begin
    if (!I_rst_n) begin
      state <= CNV_IDLE;
      rem   <= '0;
      tens  <= '0;
    end else begin
      state <= state_nxt;
      rem   <= rem_nxt;
      tens  <= tens_nxt;
    end
  end

  // A start always wins, so a new value aborts any conversion in flight.
  always_comb begin
    state_nxt = state;
    rem_nxt   = rem;
    tens_nxt  = tens;
    done      = 1'b0;
    if (start) begin
      state_nxt = CNV_SUB;
      rem_nxt   = value;
      tens_nxt  = '0;
    end else if (state == CNV_SUB) begin
      if (rem >= 7'd10) begin
        rem_nxt  = rem - 7'd10;
        tens_nxt = tens + 4'd1;
      end else begin
        done      = 1'b1;
        state_nxt = CNV_IDLE;
      end
    end
  end

  assign busy = (state == CNV_SUB);
  assign bcd  = {tens, rem[3:0]};

endmodule
`default_nettype wire

// File: rtl/light_reg_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : light_reg_ctrl
// Brief   : Bus slave holding display value/control, hex/decimal conversion
//           and blink gating for the two-digit seven-segment driver.
// Revision: 1.0
// ============================================================================
module light_reg_ctrl
  import light_pkg::*;
#(
  parameter int unsigned          P_DIV_W     = 24,
  parameter logic [P_DIV_W-1:0]   P_BLINK_RST = P_DIV_W'(5000000)
)(
  input  logic              I_clk,
  input  logic              I_rst_n,
  light_reg_ctrl_if.slave   bus,
  output logic [7:0]        O_show_num,
  output logic              O_show_en
);

  bus_state_t         bus_state, bus_state_nxt;
  logic               fire, wr;
  logic [1:0]         idx;
  logic [31:0]        rd_mux, rdata_reg;

  logic [7:0]         data_reg;
  logic [2:0]         ctrl_reg;
  logic [P_DIV_W-1:0] div_reg, blink_cnt, blink_lim;
  logic               phase, ovf;

  logic               new_dec;
  logic [7:0]         new_data;
  logic               cnv_start, cnv_busy, cnv_done;
  logic [6:0]         cnv_value;
  logic [7:0]         cnv_bcd;

  logic               unused_bits;
  assign unused_bits = ^{bus.I_addr[1:0], bus.I_wdata};

  always_ff @(posedge I_clk or negedge I_rst_n) begin
    if (!I_rst_n) bus_state <= BUS_IDLE;
    else          bus_state <= bus_state_nxt;
  end

  // The GAP state keeps a held request from being acked on back-to-back cycles.
  always_comb begin
    bus_state_nxt = bus_state;
    case (bus_state)
      BUS_IDLE: if (bus.I_req) bus_state_nxt = BUS_ACK;
      BUS_ACK:  bus_state_nxt = BUS_GAP;
      BUS_GAP:  bus_state_nxt = BUS_IDLE;
      default:  bus_state_nxt = BUS_IDLE;
    endcase
  end

  assign fire        = (bus_state == BUS_IDLE) && bus.I_req;
  assign wr          = fire && bus.I_we;
  assign idx         = bus.I_addr[3:2];
  assign bus.O_ack   = (bus_state == BUS_ACK);
  assign bus.O_rdata = rdata_reg;

  assign ovf = ctrl_reg[CTRL_DEC] && (data_reg > DEC_SAT);

  always_comb begin
    rd_mux = '0;
    case (idx)
      REG_DATA: rd_mux[7:0]         = data_reg;
      REG_CTRL: rd_mux[2:0]         = ctrl_reg;
      REG_DIV:  rd_mux[P_DIV_W-1:0] = div_reg;
      default:  rd_mux[2:0]         = {cnv_busy, ovf, phase};
    endcase
  end

  always_ff @(posedge I_clk or negedge I_rst_n) begin
    if (!I_rst_n)             rdata_reg <= '0;
    else if (fire && !bus.I_we) rdata_reg <= rd_mux;
    else                      rdata_reg <= '0;
  end

  always_ff @(posedge I_clk or negedge I_rst_n) begin
    if (!I_rst_n) begin
      data_reg <= '0;
      ctrl_reg <= 3'b001;
      div_reg  <= P_BLINK_RST;
    end else if (wr) begin
      case (idx)
        REG_DATA: data_reg <= bus.I_wdata[7:0];
        REG_CTRL: ctrl_reg <= bus.I_wdata[2:0];
        REG_DIV:  div_reg  <= bus.I_wdata[P_DIV_W-1:0];
        default:  ;
      endcase
    end
  end

  // Conversion is launched from the post-write register values.
  assign new_dec   = (idx == REG_CTRL) ? bus.I_wdata[CTRL_DEC] : ctrl_reg[CTRL_DEC];
  assign new_data  = (idx == REG_DATA) ? bus.I_wdata[7:0] : data_reg;
  assign cnv_start = wr && ((idx == REG_DATA) || (idx == REG_CTRL)) && new_dec;
  assign cnv_value = dec_clamp(new_data);

  light_bin2bcd u_bin2bcd (
    .I_clk   (I_clk),
    .I_rst_n (I_rst_n),
    .start   (cnv_start),
    .value   (cnv_value),
    .busy    (cnv_busy),
    .done    (cnv_done),
    .bcd     (cnv_bcd)
  );

  assign blink_lim = (div_reg == '0) ? '0 : div_reg - 1'b1;

  always_ff @(posedge I_clk or negedge I_rst_n) begin
    if (!I_rst_n) begin
      blink_cnt <= '0;
      phase     <= 1'b1;
    end else if (!ctrl_reg[CTRL_BLINK]) begin
      blink_cnt <= '0;
      phase     <= 1'b1;
    end else if (wr && (idx == REG_DIV)) begin
      blink_cnt <= '0;
    end else if (blink_cnt >= blink_lim) begin
      blink_cnt <= '0;
      phase     <= ~phase;
    end else begin
      blink_cnt <= blink_cnt + 1'b1;
    end
  end

  always_ff @(posedge I_clk or negedge I_rst_n) begin
    if (!I_rst_n) begin
      O_show_num <= '0;
      O_show_en  <= 1'b1;
    end else begin
      O_show_en <= ctrl_reg[CTRL_EN] & (~ctrl_reg[CTRL_BLINK] | phase);
      if (!ctrl_reg[CTRL_DEC])
        O_show_num <= data_reg;
      else if (cnv_done)
        O_show_num <= cnv_bcd;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_light_reg_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : tb_light_reg_ctrl
// Brief   : Directed self-checking bench for light_reg_ctrl.
// Revision: 1.0
// ============================================================================
module tb_light_reg_ctrl;
  import light_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] show_num;
  logic       show_en;
  int         errors = 0;
  int         checks = 0;

  always #5 clk = ~clk;

  light_reg_ctrl_if bus();

  light_reg_ctrl #(
    .P_DIV_W     (24),
    .P_BLINK_RST (24'd5000000)
  ) dut (
    .I_clk      (clk),
    .I_rst_n    (rst_n),
    .bus        (bus),
    .O_show_num (show_num),
    .O_show_en  (show_en)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic xfer(input logic we, input logic [3:0] addr, input logic [31:0] wdata,
                      output logic [31:0] rdata);
    bit got;
    got = 1'b0;
    bus.I_req   = 1'b1;
    bus.I_we    = we;
    bus.I_addr  = addr;
    bus.I_wdata = wdata;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (bus.O_ack === 1'b1) begin
        got = 1'b1;
        break;
      end
    end
    rdata     = bus.O_rdata;
    bus.I_req = 1'b0;
    check("ack_seen", 32'(got), 32'd1);
  endtask

  task automatic wr(input logic [3:0] addr, input logic [31:0] wdata);
    logic [31:0] dummy;
    xfer(1'b1, addr, wdata, dummy);
  endtask

  task automatic rd(input logic [3:0] addr, output logic [31:0] rdata);
    xfer(1'b0, addr, 32'h0, rdata);
  endtask

  task automatic wait_show(input logic [7:0] v, input int limit);
    for (int i = 0; i < limit && show_num !== v; i++) tick();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] r;
    logic [15:0] vec;
    logic [8:0]  ackv;
    logic [7:0]  tgl;
    bit          saw99;

    bus.I_req   = 1'b0;
    bus.I_we    = 1'b0;
    bus.I_addr  = 4'h0;
    bus.I_wdata = 32'h0;
    rst_n       = 1'b0;
    repeat (3) tick();
    rst_n = 1'b1;

    check("rst_show_num", 32'(show_num), 32'h00);
    check("rst_show_en", 32'(show_en), 32'd1);
    check("rst_ack", 32'(bus.O_ack), 32'd0);
    check("rst_rdata", bus.O_rdata, 32'h0);

    rd(4'h4, r); check("rd_ctrl_rst", r, 32'h1);
    rd(4'h8, r); check("rd_div_rst", r, 32'd5000000);
    rd(4'h0, r); check("rd_data_rst", r, 32'h0);
    tick();
    check("rdata_idle", bus.O_rdata, 32'h0);

    // HEX mode
    wr(4'h0, 32'h3C);
    check("hex_not_yet", 32'(show_num), 32'h00);
    tick();
    check("ack_single", 32'(bus.O_ack), 32'd0);
    check("hex_show", 32'(show_num), 32'h3C);
    rd(4'h0, r); check("rd_data_3c", r, 32'h3C);

    // DEC mode; the DATA write aborts the conversion started by CTRL
    wr(4'h4, 32'h3);
    wr(4'h0, 32'd57);
    rd(4'hC, r); check("stat_busy", r, 32'h5);
    check("busy_hold", 32'(show_num), 32'h3C);
    wait_show(8'h57, 8);
    check("dec_57", 32'(show_num), 32'h57);
    rd(4'hC, r); check("stat_idle", r, 32'h1);

    wr(4'h0, 32'd200);
    wait_show(8'h99, 12);
    check("dec_sat", 32'(show_num), 32'h99);
    rd(4'hC, r); check("stat_ovf", r, 32'h3);

    wr(4'h0, 32'd12);
    wait_show(8'h12, 12);
    check("dec_12", 32'(show_num), 32'h12);

    wr(4'h0, 32'd99);
    wr(4'h0, 32'd5);
    saw99 = 1'b0;
    for (int i = 0; i < 14; i++) begin
      tick();
      if (show_num === 8'h99) saw99 = 1'b1;
    end
    check("abort_no99", 32'(saw99), 32'd0);
    check("dec_05", 32'(show_num), 32'h05);

    // Blink with half-period 4
    wr(4'h8, 32'd4);
    wr(4'h4, 32'h5);
    vec = '0;
    for (int k = 1; k <= 16; k++) begin
      tick();
      vec[k-1] = show_en;
    end
    check("blink_div4", 32'(vec), 32'h0F0F);

    // Divider 0 toggles every clock
    wr(4'h8, 32'd0);
    tgl = '0;
    for (int k = 0; k < 8; k++) begin
      tick();
      if (k > 0 || 1'b1) tgl[k] = show_en;
    end
    check("blink_div0", 32'((tgl ^ (tgl >> 1)) & 8'h7F), 32'h7F);

    wr(4'h4, 32'h0);
    vec = '1;
    for (int k = 0; k < 6; k++) begin
      tick();
      vec[k] = show_en;
    end
    check("en_off", 32'(vec[5:0]), 32'h0);

    // Held request: one ack every three cycles
    repeat (3) tick();
    bus.I_req  = 1'b1;
    bus.I_we   = 1'b0;
    bus.I_addr = 4'h0;
    ackv[0] = bus.O_ack;
    for (int k = 1; k <= 8; k++) begin
      tick();
      ackv[k] = bus.O_ack;
    end
    bus.I_req = 1'b0;
    check("ack_pattern", 32'(ackv), 32'h092);

    // Reset in the middle of a conversion and a pending request
    wr(4'h4, 32'h3);
    wr(4'h0, 32'd57);
    check("pre_rst_show", 32'(show_num), 32'h05);
    bus.I_req  = 1'b1;
    bus.I_we   = 1'b0;
    bus.I_addr = 4'hC;
    #3 rst_n = 1'b0;
    #1;
    check("arst_show_num", 32'(show_num), 32'h00);
    check("arst_show_en", 32'(show_en), 32'd1);
    check("arst_ack", 32'(bus.O_ack), 32'd0);
    check("arst_rdata", bus.O_rdata, 32'h0);
    tick();
    check("arst_no_ack", 32'(bus.O_ack), 32'd0);
    bus.I_req = 1'b0;
    tick();
    rst_n = 1'b1;
    rd(4'h4, r); check("post_rst_ctrl", r, 32'h1);
    rd(4'hC, r); check("post_rst_stat", r, 32'h1);
    rd(4'h0, r); check("post_rst_data", r, 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
